ram_clear_sequencer: RTL and testbench

//  Multi-bank RAM clear engine for the deflate decoder and encoder memories.
//  On reset release, or on a start request, it sweeps addresses 0..cap and writes a fill word into every selected bank.
//  It drives the bank write ports through a ready/enable handshake and pulses done when the sweep completes.

---
 rtl/ram_clear_sequencer.sv | 135 +++++++++++++
 tb/tb_ram_clear_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_clear_sequencer.sv
// Multi-bank RAM clear engine: sweeps addresses 0..cap writing a fill word into the selected banks.
// Optional feature: define RAM_CLEAR_BANKMASK_EN to add the bank_mask port for start-triggered clears.
module ram_clear_sequencer #(
  parameter int                NUM_BANKS      = 4,
  parameter int                DEPTH          = 1024,
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] FILL_DEFAULT   = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    cap,
  input  logic [DATA_W-1:0]    fill_value,
`ifdef RAM_CLEAR_BANKMASK_EN
  input  logic [NUM_BANKS-1:0] bank_mask,
`endif
  input  logic                 wr_ready,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     cap_q, cap_d;
  logic [DATA_W-1:0]     fill_q, fill_d;
  logic [NUM_BANKS-1:0]  mask_q, mask_d;
  logic [NUM_BANKS-1:0]  start_mask_s;

`ifdef RAM_CLEAR_BANKMASK_EN
  assign start_mask_s = bank_mask;
`else
  assign start_mask_s = {NUM_BANKS{1'b1}};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= CLEAR_ON_RESET;
      addr_q    <= '0;
      cap_q     <= '0;
      fill_q    <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      cap_q     <= cap_d;
      fill_q    <= fill_d;
      mask_q    <= mask_d;
    end
  end

  // The post-reset clear wins over a coincident start, which is then dropped.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    cap_d     = cap_q;
    fill_d    = fill_q;
    mask_d    = mask_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d   = S_CLEAR;
          pending_d = 1'b0;
          addr_d    = '0;
          cap_d     = ADDR_W'(DEPTH - 1);
          fill_d    = FILL_DEFAULT;
          mask_d    = {NUM_BANKS{1'b1}};
        end else if (start) begin
          state_d   = S_CLEAR;
          addr_d    = '0;
          cap_d     = cap;
          fill_d    = fill_value;
          mask_d    = start_mask_s;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (wr_ready) begin
          if (addr_q == cap_q) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state, never on inputs.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      S_CLEAR: begin
        busy    = 1'b1;
        wr_en   = mask_q;
        wr_addr = addr_q;
        wr_data = fill_q;
      end
      S_DONE: begin
        done    = 1'b1;
      end
      default: begin
        busy    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_clear_sequencer.sv
// Randomized self-checking bench for ram_clear_sequencer (DEPTH=16); model tracks accepted-write counts.
module tb_ram_clear_sequencer;

  localparam int NB = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] cap;
  logic [DW-1:0] fill_value;
`ifdef RAM_CLEAR_BANKMASK_EN
  logic [NB-1:0] bank_mask;
`endif
  logic          wr_ready;
  logic [NB-1:0] wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  ram_clear_sequencer #(
    .NUM_BANKS(NB), .DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW),
    .FILL_DEFAULT(8'h00), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cap(cap), .fill_value(fill_value),
`ifdef RAM_CLEAR_BANKMASK_EN
    .bank_mask(bank_mask),
`endif
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Mask the design should apply for a start-triggered clear.
  function automatic logic [NB-1:0] exp_mask(input logic [NB-1:0] m);
`ifdef RAM_CLEAR_BANKMASK_EN
    return m;
`else
    return {NB{1'b1}};
`endif
  endfunction

  // Drive a start in the current (idle) cycle; returns in the first sweep cycle.
  task automatic issue(input logic [AW-1:0] c, input logic [DW-1:0] f, input logic [NB-1:0] m);
    cap = c;
    fill_value = f;
`ifdef RAM_CLEAR_BANKMASK_EN
    bank_mask = m;
`endif
    start = 1'b1;
    @(negedge clk);
    check_val("idle_before_start", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Expect writes 0..c of fill f with mask m; mode 0 ready high, 1 pattern 1,0,0, 2 random.
  task automatic sweep(input int c, input logic [DW-1:0] f, input logic [NB-1:0] m,
                       input int mode, input bit inject, input int abort_at);
    int acc = 0;
    int cyc = 0;
    while (acc <= c && cyc < 400) begin
      case (mode)
        0: wr_ready = 1'b1;
        1: wr_ready = (cyc % 3 == 0);
        default: wr_ready = 1'($urandom_range(1, 0));
      endcase
      if (inject) begin
        start = 1'($urandom_range(1, 0));
        cap = AW'($urandom);
        fill_value = DW'($urandom);
      end
      @(negedge clk);
      check_val("busy", {31'd0, busy}, 32'd1);
      check_val("done_in_sweep", {31'd0, done}, 32'd0);
      check_val("wr_en", {28'd0, wr_en}, {28'd0, m});
      check_val("wr_addr", {28'd0, wr_addr}, acc);
      check_val("wr_data", {24'd0, wr_data}, {24'd0, f});
      if (acc == abort_at) begin
        reset = 1'b1;
        #1;
        check_val("abort_wr_en", {28'd0, wr_en}, 32'd0);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      if (wr_ready) acc++;
      cyc++;
      @(posedge clk); #1;
    end
    check_val("accepted_writes", acc, c + 1);
    wr_ready = 1'($urandom_range(1, 0));
    start = inject ? 1'b1 : 1'b0;
    @(negedge clk);
    check_val("done_pulse", {31'd0, done}, 32'd1);
    check_val("done_wr_en", {28'd0, wr_en}, 32'd0);
    check_val("done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Two idle cycles: catches a start that was wrongly queued.
  task automatic idle_check();
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("idle_busy", {31'd0, busy}, 32'd0);
      check_val("idle_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [AW-1:0] c;
    logic [DW-1:0] f;
    logic [NB-1:0] m;
    reset = 1'b1;
    start = 1'b0;
    cap = '0;
    fill_value = '0;
`ifdef RAM_CLEAR_BANKMASK_EN
    bank_mask = '0;
`endif
    wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_wr_en", {28'd0, wr_en}, 32'd0);
    check_val("rst_addr", {28'd0, wr_addr}, 32'd0);
    check_val("rst_data", {24'd0, wr_data}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);

    // Reset-triggered full clear; a coincident start must be dropped.
    @(posedge clk); #1;
    reset = 1'b0;
    cap = 4'd2;
    fill_value = 8'h77;
    start = 1'b1;
    @(negedge clk);
    check_val("post_rst_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    sweep(DEPTH - 1, 8'h00, 4'hF, 0, 1'b0, -1);
    idle_check();

    // Directed: cap=3 fill A5, then cap=0, then stall pattern on cap=5.
    issue(4'd3, 8'hA5, 4'hF);
    sweep(3, 8'hA5, 4'hF, 0, 1'b0, -1);
    issue(4'd0, 8'h3C, 4'hF);
    sweep(0, 8'h3C, 4'hF, 0, 1'b0, -1);
    idle_check();
    issue(4'd5, 8'h5A, 4'hF);
    sweep(5, 8'h5A, 4'hF, 1, 1'b1, -1);
    idle_check();

`ifdef RAM_CLEAR_BANKMASK_EN
    issue(4'd2, 8'hC3, 4'b0101);
    sweep(2, 8'hC3, 4'b0101, 0, 1'b0, -1);
    issue(4'd3, 8'h11, 4'b0000);
    sweep(3, 8'h11, 4'b0000, 2, 1'b0, -1);
    idle_check();
`endif

    // Reset in the middle of a sweep, then the automatic full restart.
    issue(4'd15, 8'h99, 4'hF);
    sweep(15, 8'h99, 4'hF, 0, 1'b0, 7);
    @(negedge clk);
    check_val("restart_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    sweep(DEPTH - 1, 8'h00, 4'hF, 0, 1'b0, -1);
    idle_check();

    // Randomized clears, sometimes back-to-back right after done.
    for (int i = 0; i < 24; i++) begin
      c = AW'($urandom);
      f = DW'($urandom);
      m = NB'($urandom);
      issue(c, f, m);
      sweep(int'(c), f, exp_mask(m), int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)), -1);
      if ($urandom_range(1, 0) == 0) idle_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
